// File: rtl/token_table_loader.sv
// Token table loader: optionally zeroes the whole table, then streams count
// words from a valid/ready source into it while accumulating a checksum.
module token_table_loader #(
  parameter int WIDTH = 32,
  parameter int SIZE  = 102,
  parameter int CW    = 7
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             clear_en,
  input  logic [CW-1:0]    count,
  input  logic             abort,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             wme,
  output logic [WIDTH-1:0] waddr,
  output logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic [WIDTH-1:0] checksum
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_CLEAR = 2'd1;
  localparam logic [1:0] S_LOAD  = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [CW-1:0] LAST_IDX = CW'(SIZE - 1);
  localparam logic [CW-1:0] MAX_CNT  = CW'(SIZE);

  logic [1:0]    state;
  logic [CW-1:0] idx;
  logic [CW-1:0] cnt_q;
  logic          accept;
  logic          clear_wr;
  logic          legal_req;

  // Abort suppresses the write and the handshake in the very cycle it is seen.
  always_comb begin
    in_ready  = (state == S_LOAD) && !abort;
    accept    = in_ready && in_valid;
    clear_wr  = (state == S_CLEAR) && !abort;
    wme       = clear_wr || accept;
    waddr     = '0;
    wdata     = '0;
    if (wme) begin
      waddr = {{(WIDTH-CW){1'b0}}, idx};
    end
    if (accept) begin
      wdata = in_data;
    end
    busy      = (state != S_IDLE);
    done      = (state == S_DONE);
    legal_req = (count != '0) && (count <= MAX_CNT);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= S_IDLE;
      idx      <= '0;
      cnt_q    <= '0;
      checksum <= '0;
      error    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            if (legal_req) begin
              cnt_q    <= count;
              idx      <= '0;
              checksum <= '0;
              error    <= 1'b0;
              state    <= clear_en ? S_CLEAR : S_LOAD;
            end else begin
              error <= 1'b1;
            end
          end
        end
        S_CLEAR: begin
          if (abort) begin
            idx   <= '0;
            state <= S_IDLE;
          end else if (idx == LAST_IDX) begin
            idx   <= '0;
            state <= S_LOAD;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        S_LOAD: begin
          if (abort) begin
            idx   <= '0;
            state <= S_IDLE;
          end else if (accept) begin
            checksum <= checksum + in_data;
            // Wrap idx on the final word so a full-table load never leaves idx at SIZE.
            if (idx == cnt_q - 1'b1) begin
              idx   <= '0;
              state <= S_DONE;
            end else begin
              idx <= idx + 1'b1;
            end
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_token_table_loader.sv
// Self-checking bench for token_table_loader: a per-cycle vector table for the
// load/error/abort flows plus directed sequences for clearing and reset.
module tb_token_table_loader;

  logic        clk;
  logic        reset;
  logic        start;
  logic        clear_en;
  logic [6:0]  count;
  logic        abort;
  logic        in_valid;
  logic [31:0] in_data;
  logic        in_ready;
  logic        wme;
  logic [31:0] waddr;
  logic [31:0] wdata;
  logic        busy;
  logic        done;
  logic        error;
  logic [31:0] checksum;

  int nCompared;
  int nMismatched;

  typedef struct {
    logic        start;
    logic        clear_en;
    logic [6:0]  count;
    logic        abort;
    logic        in_valid;
    logic [31:0] in_data;
    logic        wme;
    logic [31:0] waddr;
    logic [31:0] wdata;
    logic        in_ready;
    logic        busy;
    logic        done;
    logic        error;
    logic [31:0] checksum;
  } vec_t;

  vec_t vecs[$];

  token_table_loader #(.WIDTH(32), .SIZE(102), .CW(7)) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .clear_en(clear_en),
    .count(count),
    .abort(abort),
    .in_valid(in_valid),
    .in_data(in_data),
    .in_ready(in_ready),
    .wme(wme),
    .waddr(waddr),
    .wdata(wdata),
    .busy(busy),
    .done(done),
    .error(error),
    .checksum(checksum)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nCompared++;
    if (act !== exp) begin
      nMismatched++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic addVec(input logic st, input logic ce, input logic [6:0] cnt, input logic ab,
                        input logic iv, input logic [31:0] d, input logic ewme,
                        input logic [31:0] eaddr, input logic [31:0] edata, input logic erdy,
                        input logic ebusy, input logic edone, input logic eerr,
                        input logic [31:0] ecs);
    vec_t v;
    v.start = st; v.clear_en = ce; v.count = cnt; v.abort = ab;
    v.in_valid = iv; v.in_data = d; v.wme = ewme; v.waddr = eaddr;
    v.wdata = edata; v.in_ready = erdy; v.busy = ebusy; v.done = edone;
    v.error = eerr; v.checksum = ecs;
    vecs.push_back(v);
  endtask

  task automatic applyStimulus(input logic st, input logic ce, input logic [6:0] cnt,
                               input logic ab, input logic iv, input logic [31:0] d);
    @(negedge clk);
    start    = st;
    clear_en = ce;
    count    = cnt;
    abort    = ab;
    in_valid = iv;
    in_data  = d;
    #1;
  endtask

  task automatic checkIdleOutputs(input string tag);
    checkOutput({tag, ".wme"},      32'(wme), 32'd0);
    checkOutput({tag, ".in_ready"}, 32'(in_ready), 32'd0);
    checkOutput({tag, ".waddr"},    waddr, 32'd0);
    checkOutput({tag, ".wdata"},    wdata, 32'd0);
    checkOutput({tag, ".busy"},     32'(busy), 32'd0);
    checkOutput({tag, ".done"},     32'(done), 32'd0);
  endtask

  initial begin
    nCompared   = 0;
    nMismatched = 0;
    start = 0; clear_en = 0; count = '0; abort = 0; in_valid = 0; in_data = '0;
    reset = 1'b0;

    //      st ce cnt ab iv data           wme addr data           rdy bsy dn er checksum
    // count=3, words 5,6,7 back to back
    addVec(1, 0, 3,  0, 0, 32'd0,          0, 0, 32'd0,          0, 0, 0, 0, 32'd0);
    addVec(0, 0, 0,  0, 1, 32'd5,          1, 0, 32'd5,          1, 1, 0, 0, 32'd0);
    addVec(0, 0, 0,  0, 1, 32'd6,          1, 1, 32'd6,          1, 1, 0, 0, 32'd5);
    addVec(0, 0, 0,  0, 1, 32'd7,          1, 2, 32'd7,          1, 1, 0, 0, 32'd11);
    addVec(0, 0, 0,  0, 0, 32'd0,          0, 0, 32'd0,          0, 1, 1, 0, 32'd18);
    addVec(0, 0, 0,  0, 0, 32'd0,          0, 0, 32'd0,          0, 0, 0, 0, 32'd18);
    // count=4 with in_valid toggling; a stray illegal start mid-load is ignored
    addVec(1, 0, 4,  0, 0, 32'd0,          0, 0, 32'd0,          0, 0, 0, 0, 32'd18);
    addVec(0, 0, 0,  0, 1, 32'd10,         1, 0, 32'd10,         1, 1, 0, 0, 32'd0);
    addVec(0, 0, 0,  0, 0, 32'd99,         0, 0, 32'd0,          1, 1, 0, 0, 32'd10);
    addVec(1, 0, 0,  0, 1, 32'd20,         1, 1, 32'd20,         1, 1, 0, 0, 32'd10);
    addVec(0, 0, 0,  0, 0, 32'd0,          0, 0, 32'd0,          1, 1, 0, 0, 32'd30);
    addVec(0, 0, 0,  0, 1, 32'd30,         1, 2, 32'd30,         1, 1, 0, 0, 32'd30);
    addVec(0, 0, 0,  0, 0, 32'd0,          0, 0, 32'd0,          1, 1, 0, 0, 32'd60);
    addVec(0, 0, 0,  0, 1, 32'd40,         1, 3, 32'd40,         1, 1, 0, 0, 32'd60);
    addVec(0, 0, 0,  0, 0, 32'd0,          0, 0, 32'd0,          0, 1, 1, 0, 32'd100);
    // illegal counts 0 and 103, then a legal start that loads a wrapping checksum
    addVec(1, 0, 0,  0, 0, 32'd0,          0, 0, 32'd0,          0, 0, 0, 0, 32'd100);
    addVec(1, 0, 103, 0, 0, 32'd0,         0, 0, 32'd0,          0, 0, 0, 1, 32'd100);
    addVec(0, 0, 0,  0, 1, 32'd1,          0, 0, 32'd0,          0, 0, 0, 1, 32'd100);
    addVec(1, 0, 2,  0, 0, 32'd0,          0, 0, 32'd0,          0, 0, 0, 1, 32'd100);
    addVec(0, 0, 0,  0, 1, 32'hFFFFFFFF,   1, 0, 32'hFFFFFFFF,   1, 1, 0, 0, 32'd0);
    addVec(0, 0, 0,  0, 1, 32'd2,          1, 1, 32'd2,          1, 1, 0, 0, 32'hFFFFFFFF);
    addVec(0, 0, 0,  1, 0, 32'd0,          0, 0, 32'd0,          0, 1, 1, 0, 32'd1);
    // abort on the second word of count=5, then immediate restart
    addVec(1, 0, 5,  0, 0, 32'd0,          0, 0, 32'd0,          0, 0, 0, 0, 32'd1);
    addVec(0, 0, 0,  0, 1, 32'hA1,         1, 0, 32'hA1,         1, 1, 0, 0, 32'd0);
    addVec(0, 0, 0,  1, 1, 32'hA2,         0, 0, 32'd0,          0, 1, 0, 0, 32'hA1);
    addVec(1, 0, 1,  0, 0, 32'd0,          0, 0, 32'd0,          0, 0, 0, 0, 32'hA1);
    addVec(0, 0, 0,  0, 1, 32'd7,          1, 0, 32'd7,          1, 1, 0, 0, 32'd0);
    addVec(0, 0, 0,  0, 0, 32'd0,          0, 0, 32'd0,          0, 1, 1, 0, 32'd7);
    addVec(0, 0, 0,  1, 1, 32'd3,          0, 0, 32'd0,          0, 0, 0, 0, 32'd7);

    #2;
    checkIdleOutputs("rst");
    checkOutput("rst.error",    32'(error), 32'd0);
    checkOutput("rst.checksum", checksum, 32'd0);
    @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].start, vecs[i].clear_en, vecs[i].count,
                    vecs[i].abort, vecs[i].in_valid, vecs[i].in_data);
      checkOutput($sformatf("v%0d.wme", i),      32'(wme),      32'(vecs[i].wme));
      checkOutput($sformatf("v%0d.waddr", i),    waddr,         vecs[i].waddr);
      checkOutput($sformatf("v%0d.wdata", i),    wdata,         vecs[i].wdata);
      checkOutput($sformatf("v%0d.in_ready", i), 32'(in_ready), 32'(vecs[i].in_ready));
      checkOutput($sformatf("v%0d.busy", i),     32'(busy),     32'(vecs[i].busy));
      checkOutput($sformatf("v%0d.done", i),     32'(done),     32'(vecs[i].done));
      checkOutput($sformatf("v%0d.error", i),    32'(error),    32'(vecs[i].error));
      checkOutput($sformatf("v%0d.checksum", i), checksum,      vecs[i].checksum);
    end

    // Clear then load two words; source is offering data during the clear.
    applyStimulus(1, 1, 2, 0, 1, 32'hDEAD0000);
    checkOutput("clr.start.busy", 32'(busy), 32'd0);
    for (int i = 0; i < 102; i++) begin
      applyStimulus(0, 0, 0, 0, 1, 32'hDEAD0000 + 32'(i));
      checkOutput($sformatf("clr%0d.wme", i),      32'(wme), 32'd1);
      checkOutput($sformatf("clr%0d.waddr", i),    waddr, 32'(i));
      checkOutput($sformatf("clr%0d.wdata", i),    wdata, 32'd0);
      checkOutput($sformatf("clr%0d.in_ready", i), 32'(in_ready), 32'd0);
    end
    applyStimulus(0, 0, 0, 0, 1, 32'h0000AAAA);
    checkOutput("clrA.wme",      32'(wme), 32'd1);
    checkOutput("clrA.waddr",    waddr, 32'd0);
    checkOutput("clrA.wdata",    wdata, 32'h0000AAAA);
    checkOutput("clrA.in_ready", 32'(in_ready), 32'd1);
    applyStimulus(0, 0, 0, 0, 1, 32'h0000BBBB);
    checkOutput("clrB.waddr",    waddr, 32'd1);
    checkOutput("clrB.wdata",    wdata, 32'h0000BBBB);
    applyStimulus(0, 0, 0, 0, 0, 32'd0);
    checkOutput("clr.done",      32'(done), 32'd1);
    checkOutput("clr.checksum",  checksum, 32'h00016665);
    applyStimulus(0, 0, 0, 0, 0, 32'd0);
    checkOutput("clr.idle.busy", 32'(busy), 32'd0);

    // Reset pulsed low in the middle of a clear.
    applyStimulus(1, 1, 3, 0, 0, 32'd0);
    for (int i = 0; i < 10; i++) applyStimulus(0, 0, 0, 0, 0, 32'd0);
    checkOutput("mid.wme",   32'(wme), 32'd1);
    checkOutput("mid.waddr", waddr, 32'd9);
    #2;
    reset = 1'b0;
    #1;
    checkIdleOutputs("arst");
    checkOutput("arst.error",    32'(error), 32'd0);
    checkOutput("arst.checksum", checksum, 32'd0);
    for (int i = 0; i < 2; i++) begin
      applyStimulus(0, 0, 0, 0, 1, 32'd1);
      checkIdleOutputs($sformatf("hold%0d", i));
    end
    @(negedge clk);
    reset = 1'b1; start = 1; count = 7'd1; clear_en = 0; in_valid = 0;
    #1;
    checkIdleOutputs("rel");
    applyStimulus(0, 0, 0, 0, 1, 32'd9);
    checkOutput("rel.wme",      32'(wme), 32'd1);
    checkOutput("rel.in_ready", 32'(in_ready), 32'd1);
    checkOutput("rel.waddr",    waddr, 32'd0);
    applyStimulus(0, 0, 0, 0, 0, 32'd0);
    checkOutput("rel.done",     32'(done), 32'd1);
    checkOutput("rel.checksum", checksum, 32'd9);
    applyStimulus(0, 0, 0, 0, 0, 32'd0);
    checkIdleOutputs("end");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
